// File: rtl/nova_tohost_mailbox.sv
// nova_tohost_mailbox: BAR1 AXI4-Lite responder exposing the TOHOST mailbox and
// a STATUS word, plus the run/reset sequencer that releases core_rst_n a fixed
// number of cycles after the virtual DIP run request is seen.
module nova_tohost_mailbox #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h0008_C120,
    parameter logic [31:0] STATUS_ADDR  = 32'h0008_C124,
    parameter int unsigned RST_HOLD_CYC = 16
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    // AXI4-Lite write address / data / response
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    // AXI4-Lite read address / data
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    // core side
    input  logic        vdip_run,
    input  logic        core_tohost_we,
    input  logic [31:0] core_tohost_wdata,
    output logic        core_rst_n,
    output logic        tohost_done
);

    localparam int unsigned CNT_W     = $clog2(RST_HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              core_rst_n_q;
    logic              vdip_meta_q, vdip_s_q;
    logic              rdy_en_q;

    logic              aw_full_q, w_full_q;
    logic [31:0]       aw_addr_q, w_data_q;
    logic [3:0]        w_strb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic [1:0]        rresp_q;

    logic [31:0]       tohost_q, tohost_d;
    logic              done_q, done_d;

    logic              commit;
    logic              wr_hit_tohost;
    logic              core_wr_ok;

    // Two-flop synchroniser for the asynchronous run request.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            vdip_meta_q <= 1'b0;
            vdip_s_q    <= 1'b0;
        end else begin
            vdip_meta_q <= vdip_run;
            vdip_s_q    <= vdip_meta_q;
        end
    end

    // Run/reset sequencer with registered core reset output.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    core_rst_n_q <= 1'b0;
                    if (vdip_s_q) begin
                        state_q <= ST_RELEASE;
                        cnt_q   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (!vdip_s_q) begin
                        state_q <= ST_HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_RUN;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!vdip_s_q) begin
                        state_q      <= ST_HOLD;
                        core_rst_n_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_HOLD;
                    core_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    // Keeps every ready low while reset is asserted and for the first cycle after.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) rdy_en_q <= 1'b0;
        else             rdy_en_q <= 1'b1;
    end

    assign s_awready = rdy_en_q & ~aw_full_q & ~bvalid_q;
    assign s_wready  = rdy_en_q & ~w_full_q  & ~bvalid_q;
    assign s_arready = rdy_en_q & ~rvalid_q;

    assign commit        = aw_full_q & w_full_q;
    assign wr_hit_tohost = (aw_addr_q[31:2] == TOHOST_ADDR[31:2]);
    assign core_wr_ok    = core_tohost_we & (state_q == ST_RUN);

    // AW/W holding registers and the write response.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (s_awvalid && s_awready) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_full_q <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_hit_tohost ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Next TOHOST / done value: core write overrides a same-cycle host commit.
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        tohost_d = tohost_q;
        done_d   = done_q;
        if (commit && wr_hit_tohost) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) tohost_d[8*b +: 8] = w_data_q[8*b +: 8];
            end
            done_d = 1'b0;
        end
        if (core_wr_ok) begin
            tohost_d = core_tohost_wdata;
            done_d   = 1'b1;
        end
    end

    // Mailbox registers; only the block reset clears them.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            tohost_q <= '0;
            done_q   <= 1'b0;
        end else begin
            tohost_q <= tohost_d;
            done_q   <= done_d;
        end
    end

    // Read channel: data registered on the AR handshake, held until accepted.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (s_arvalid && s_arready) begin
            rvalid_q <= 1'b1;
            if (s_araddr[31:2] == TOHOST_ADDR[31:2]) begin
                rdata_q <= tohost_q;
                rresp_q <= RESP_OKAY;
            end else if (s_araddr[31:2] == STATUS_ADDR[31:2]) begin
                rdata_q <= {28'h0, state_q, core_rst_n_q, done_q};
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end
        end else if (rvalid_q && s_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_bvalid    = bvalid_q;
    assign s_bresp     = bresp_q;
    assign s_rvalid    = rvalid_q;
    assign s_rdata     = rdata_q;
    assign s_rresp     = rresp_q;
    assign core_rst_n  = core_rst_n_q;
    assign tohost_done = done_q;

endmodule

// File: tb/tb_nova_tohost_mailbox.sv
// Self-checking bench for nova_tohost_mailbox: directed scenarios plus a
// randomized AXI/core traffic phase checked against a register-level model.
module tb_nova_tohost_mailbox;

    localparam logic [31:0] TOHOST = 32'h0008_C120;
    localparam logic [31:0] STATUS = 32'h0008_C124;
    localparam logic [31:0] UNMAP  = 32'h0008_C130;
    localparam int          HOLD   = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic        vdip_run, core_tohost_we, core_rst_n, tohost_done;
    logic [31:0] core_tohost_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [31:0] m_tohost;
    logic        m_done;
    logic [1:0]  m_phase;   // 0 = held in reset, 2 = core running
    logic        m_run;

    always #5 clk = ~clk;

    nova_tohost_mailbox #(.RST_HOLD_CYC(HOLD)) dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .vdip_run(vdip_run), .core_tohost_we(core_tohost_we),
        .core_tohost_wdata(core_tohost_wdata), .core_rst_n(core_rst_n),
        .tohost_done(tohost_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_tohost(input logic [31:0] a);
        return a[31:2] == TOHOST[31:2];
    endfunction

    function automatic bit is_status(input logic [31:0] a);
        return a[31:2] == STATUS[31:2];
    endfunction

    function automatic logic [31:0] exp_status();
        return {28'h0, m_phase, m_run, m_done};
    endfunction

    task automatic model_reset();
        m_tohost = '0;
        m_done   = 1'b0;
        m_phase  = 2'd0;
        m_run    = 1'b0;
    endtask

    // w_lead > 0: W leads AW by w_lead cycles; w_lead < 0: AW leads W.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int b_delay,
                             input bit core_hit, input logic [31:0] core_data);
        int aw_start = (w_lead > 0) ? w_lead : 0;
        int w_start  = (w_lead < 0) ? -w_lead : 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        logic [1:0] exp_resp;
        s_awaddr = addr;
        s_wdata  = data;
        s_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_awvalid = !aw_done && cyc >= aw_start;
            s_wvalid  = !w_done && cyc >= w_start;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        // both captured: this is the commit cycle
        check("bvalid_before_commit", s_bvalid, 1'b0);
        if (core_hit) begin
            core_tohost_we    = 1'b1;
            core_tohost_wdata = core_data;
        end
        tick();
        core_tohost_we = 1'b0;
        exp_resp = is_tohost(addr) ? 2'b00 : 2'b10;
        if (is_tohost(addr)) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_tohost[8*b +: 8] = data[8*b +: 8];
            m_done = 1'b0;
        end
        if (core_hit && m_run) begin
            m_tohost = core_data;
            m_done   = 1'b1;
        end
        check("bvalid", s_bvalid, 1'b1);
        check("bresp", s_bresp, exp_resp);
        for (int i = 0; i < b_delay; i++) begin
            check("awready_blocked", s_awready, 1'b0);
            check("wready_blocked", s_wready, 1'b0);
            tick();
            check("bvalid_held", s_bvalid, 1'b1);
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("bvalid_clear", s_bvalid, 1'b0);
        tick();
        check("no_second_commit", s_bvalid, 1'b0);
        check("tohost_done", tohost_done, m_done);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_delay);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int cyc = 0;
        if (is_tohost(addr))      begin exp_data = m_tohost;     exp_resp = 2'b00; end
        else if (is_status(addr)) begin exp_data = exp_status(); exp_resp = 2'b00; end
        else                      begin exp_data = 32'h0;        exp_resp = 2'b10; end
        s_araddr  = addr;
        s_arvalid = 1'b1;
        while (!s_arready && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!s_arready) begin
            s_arvalid = 1'b0;
            check("rd_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        tick();
        s_arvalid = 1'b0;
        check("rvalid", s_rvalid, 1'b1);
        check("rdata", s_rdata, exp_data);
        check("rresp", s_rresp, exp_resp);
        for (int i = 0; i < r_delay; i++) begin
            tick();
            check("rdata_held", s_rdata, exp_data);
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        check("rvalid_clear", s_rvalid, 1'b0);
    endtask

    task automatic core_write(input logic [31:0] data);
        core_tohost_we    = 1'b1;
        core_tohost_wdata = data;
        tick();
        core_tohost_we = 1'b0;
        if (m_run) begin
            m_tohost = data;
            m_done   = 1'b1;
        end
        check("core_wr_done", tohost_done, m_done);
    endtask

    task automatic start_run();
        vdip_run = 1'b1;
        tick();                              // first edge that samples the request
        for (int i = 0; i < HOLD + 1; i++) tick();
        check("core_rst_n_before_release", core_rst_n, 1'b0);
        tick();                              // 2 + HOLD edges after the first sample
        check("core_rst_n_release", core_rst_n, 1'b1);
        m_phase = 2'd2;
        m_run   = 1'b1;
    endtask

    initial begin
        logic [31:0] addr, data;
        int          op;
        rst_n = 1'b0;
        s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0;
        s_bready = 0; s_arvalid = 0; s_araddr = 0; s_rready = 0;
        vdip_run = 0; core_tohost_we = 0; core_tohost_wdata = 0;
        model_reset();
        repeat (3) tick();
        check("rst_awready", s_awready, 1'b0);
        check("rst_arready", s_arready, 1'b0);
        check("rst_bvalid", s_bvalid, 1'b0);
        check("rst_rdata", s_rdata, 32'h0);
        check("rst_core_rst_n", core_rst_n, 1'b0);
        check("rst_done", tohost_done, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        axi_read(STATUS, 0);
        axi_write(TOHOST, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
        axi_read(TOHOST, 1);

        start_run();
        axi_read(STATUS, 0);                 // RUN, released, not done: 0xA

        core_write(32'h0);
        axi_read(TOHOST, 0);
        axi_write(TOHOST, 32'h0000_1234, 4'hF, 0, 0, 0, 0);

        axi_write(TOHOST, 32'hDEAD_BEEF, 4'hF, -2, 0, 0, 0);
        axi_write(TOHOST, 32'hAAAA_5555, 4'h3, 3, 5, 0, 0);
        axi_read(TOHOST, 0);                 // 0xDEAD5555

        axi_write(UNMAP, 32'h1111_2222, 4'hF, 0, 1, 0, 0);
        axi_read(UNMAP, 0);
        axi_write(STATUS, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0);
        axi_write(TOHOST, 32'hFFFF_FFFF, 4'h0, 0, 0, 0, 0);
        axi_read(TOHOST, 0);

        axi_write(TOHOST, 32'h1, 4'hF, 0, 0, 1, 32'h0);
        axi_read(TOHOST, 0);
        axi_read(STATUS, 0);

        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0, 1:    addr = TOHOST | 32'($urandom_range(0, 3));
                2:       addr = STATUS;
                default: addr = $urandom;
            endcase
            data = $urandom;
            if (op <= 2)
                axi_write(addr, data, 4'($urandom), $urandom_range(0, 6) - 3,
                          $urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom);
            else if (op <= 4)
                axi_read(addr, $urandom_range(0, 2));
            else
                core_write(data);
        end
        axi_read(TOHOST, 0);

        // reset with a write response pending
        s_awaddr = TOHOST; s_wdata = 32'h5A5A_5A5A; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        check("pre_rst_bvalid", s_bvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", s_bvalid, 1'b0);
        check("mid_rst_core_rst_n", core_rst_n, 1'b0);
        check("mid_rst_awready", s_awready, 1'b0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        axi_read(TOHOST, 0);
        for (int i = 0; i < 2 * HOLD; i++) tick();
        m_phase = 2'd2;
        m_run   = 1'b1;
        axi_read(STATUS, 0);

        // run request withdrawn while running
        core_write(32'hC0DE_0001);
        vdip_run = 1'b0;
        tick();
        tick();
        check("drop_still_running", core_rst_n, 1'b1);
        tick();
        check("drop_core_rst_n", core_rst_n, 1'b0);
        m_phase = 2'd0;
        m_run   = 1'b0;
        axi_read(STATUS, 0);
        axi_read(TOHOST, 0);
        core_write(32'hBAD0_BAD0);           // ignored while held
        axi_read(TOHOST, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
